// File: rtl/rbm_vote_classifier.sv
// Accumulates per-class RBM iteration outputs with saturation, then runs a
// sequential argmax scan and presents the winning class under valid/ready.
module rbm_vote_classifier #(
  parameter int unsigned out_dim          = 2,
  parameter int unsigned output_bitlength = 12,
  parameter int unsigned acc_bitlength    = 20,
  parameter int unsigned class_bitlength  = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [out_dim*output_bitlength-1:0]   in_sample,
  input  logic                                  in_last,
  output logic                                  class_valid,
  input  logic                                  class_ready,
  output logic [class_bitlength-1:0]            class_id,
  output logic [acc_bitlength-1:0]              class_score,
  output logic                                  class_tie,
  output logic                                  sat_flag,
  output logic                                  busy
);

  localparam int unsigned SUM_W = acc_bitlength + 1;
  localparam logic [class_bitlength-1:0] LAST_IDX = class_bitlength'(out_dim - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, HOLD} state_t;

  state_t                     state, state_next;
  logic [acc_bitlength-1:0]   acc     [out_dim];
  logic [acc_bitlength-1:0]   acc_new [out_dim];
  logic [SUM_W-1:0]           sum     [out_dim];
  logic                       clamp_any;
  logic                       accept;
  logic [acc_bitlength-1:0]   scan_score;
  logic [acc_bitlength-1:0]   best_score;
  logic [class_bitlength-1:0] best_idx;
  logic [class_bitlength-1:0] scan_idx;
  logic                       best_tie;

  assign accept = in_valid & in_ready;

  // Per-class load (first sample of a run) or saturating add
  always_comb begin
    clamp_any = 1'b0;
    for (int i = 0; i < int'(out_dim); i++) begin
      sum[i]     = {1'b0, acc[i]} + SUM_W'(in_sample[i*output_bitlength +: output_bitlength]);
      acc_new[i] = acc[i];
      if (state == IDLE) begin
        acc_new[i] = acc_bitlength'(in_sample[i*output_bitlength +: output_bitlength]);
      end else if (sum[i][acc_bitlength]) begin
        acc_new[i] = '1;
        clamp_any  = 1'b1;
      end else begin
        acc_new[i] = sum[i][acc_bitlength-1:0];
      end
    end
  end

  // Score of the class currently being scanned
  always_comb begin
    scan_score = '0;
    for (int i = 0; i < int'(out_dim); i++) begin
      if (class_bitlength'(i) == scan_idx) scan_score = acc[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: if (accept) state_next = in_last ? DECIDE : ACCUM;
      DECIDE:      if (scan_idx == LAST_IDX) state_next = HOLD;
      HOLD:        if (class_valid && class_ready) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Datapath, scan registers and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(out_dim); i++) acc[i] <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      sat_flag    <= 1'b0;
      best_score  <= '0;
      best_idx    <= '0;
      best_tie    <= 1'b0;
      scan_idx    <= '0;
      class_valid <= 1'b0;
      class_id    <= '0;
      class_score <= '0;
      class_tie   <= 1'b0;
    end else begin
      in_ready <= (state_next == IDLE) || (state_next == ACCUM);
      busy     <= (state_next != IDLE);
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            for (int i = 0; i < int'(out_dim); i++) acc[i] <= acc_new[i];
            if (state == IDLE)  sat_flag <= 1'b0;
            else if (clamp_any) sat_flag <= 1'b1;
            if (in_last) begin
              best_score <= acc_new[0];
              best_idx   <= '0;
              best_tie   <= 1'b0;
              scan_idx   <= class_bitlength'(1);
            end
          end
        end
        DECIDE: begin
          // Strict > keeps the lowest index on ties
          if (scan_score > best_score) begin
            best_score <= scan_score;
            best_idx   <= scan_idx;
            best_tie   <= 1'b0;
          end else if (scan_score == best_score) begin
            best_tie <= 1'b1;
          end
          scan_idx <= scan_idx + class_bitlength'(1);
        end
        HOLD: begin
          if (!class_valid) begin
            class_valid <= 1'b1;
            class_id    <= best_idx;
            class_score <= best_score;
            class_tie   <= best_tie;
          end else if (class_ready) begin
            class_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_vote_classifier.sv
// Scoreboard bench for rbm_vote_classifier: a saturating reference model
// pushes expected decisions on each final sample; decisions are popped and compared.
module tb_rbm_vote_classifier;

  localparam int OUT_DIM = 2;
  localparam int OW      = 12;
  localparam int AW      = 20;
  localparam int CW      = 1;

  logic                  clock;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_DIM*OW-1:0] in_sample;
  logic                  in_last;
  logic                  class_valid;
  logic                  class_ready;
  logic [CW-1:0]         class_id;
  logic [AW-1:0]         class_score;
  logic                  class_tie;
  logic                  sat_flag;
  logic                  busy;

  typedef struct {
    logic [CW-1:0] id;
    logic [AW-1:0] score;
    logic          tie;
    logic          sat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [AW-1:0] m_acc [OUT_DIM];
  logic        m_sat;
  bit          m_first = 1'b1;

  rbm_vote_classifier #(
    .out_dim(OUT_DIM), .output_bitlength(OW), .acc_bitlength(AW), .class_bitlength(CW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_last(in_last), .class_valid(class_valid),
    .class_ready(class_ready), .class_id(class_id), .class_score(class_score),
    .class_tie(class_tie), .sat_flag(sat_flag), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_accept(input logic [OW-1:0] c0, input logic [OW-1:0] c1, input logic last);
    logic [OW-1:0] s [OUT_DIM];
    longint        t;
    logic [AW-1:0] best;
    exp_t          e;
    s[0] = c0;
    s[1] = c1;
    if (m_first) m_sat = 1'b0;
    for (int i = 0; i < OUT_DIM; i++) begin
      if (m_first) begin
        m_acc[i] = AW'(s[i]);
      end else begin
        t = longint'(m_acc[i]) + longint'(s[i]);
        if (t > ((longint'(1) << AW) - 1)) begin
          m_acc[i] = '1;
          m_sat    = 1'b1;
        end else begin
          m_acc[i] = AW'(t);
        end
      end
    end
    m_first = 1'b0;
    if (last) begin
      best = m_acc[0];
      e.id = '0;
      e.tie = 1'b0;
      for (int i = 1; i < OUT_DIM; i++) begin
        if (m_acc[i] > best) begin
          best = m_acc[i];
          e.id = CW'(i);
          e.tie = 1'b0;
        end else if (m_acc[i] == best) begin
          e.tie = 1'b1;
        end
      end
      e.score = best;
      e.sat   = m_sat;
      sb.push_back(e);
      m_first = 1'b1;
    end
  endtask

  task automatic send(input logic [OW-1:0] c0, input logic [OW-1:0] c1, input logic last);
    int n = 0;
    in_valid  = 1'b1;
    in_sample = {c1, c0};
    in_last   = last;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clock);
    model_accept(c0, c1, last);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_latency(input string name);
    for (int k = 1; k <= OUT_DIM; k++) begin
      @(posedge clock); #1;
      checks++;
      if (class_valid !== (k == OUT_DIM) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_latency edge+%0d: valid=%0b in_ready=%0b, required valid=%0b in_ready=0",
                 name, k, class_valid, in_ready, (k == OUT_DIM));
      end
    end
  endtask

  task automatic check_decision(input string name, output exp_t e);
    int n = 0;
    while (!class_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (!class_valid) begin
      errors++;
      $display("FAIL %s_timeout: class_valid=0, required 1", name);
      e = '{id: '0, score: '0, tie: 1'b0, sat: 1'b0};
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: decision with empty scoreboard", name);
      e = '{id: '0, score: '0, tie: 1'b0, sat: 1'b0};
      return;
    end
    e = sb.pop_front();
    if ({class_id, class_score, class_tie, sat_flag} !== {e.id, e.score, e.tie, e.sat}) begin
      errors++;
      $display("FAIL %s_decision: id=%0d score=%0d tie=%0b sat=%0b, required id=%0d score=%0d tie=%0b sat=%0b",
               name, class_id, class_score, class_tie, sat_flag, e.id, e.score, e.tie, e.sat);
    end
  endtask

  task automatic handshake(input string name);
    class_ready = 1'b1;
    @(posedge clock); #1;
    class_ready = 1'b0;
    checks++;
    if (class_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: valid=%0b in_ready=%0b busy=%0b, required 0/1/0",
               name, class_valid, in_ready, busy);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({in_ready, class_valid, class_id, class_score, class_tie, sat_flag, busy} !==
        {1'b1, 1'b0, CW'(0), AW'(0), 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: rdy=%0b valid=%0b id=%0d score=%0d tie=%0b sat=%0b busy=%0b, required 1/0/0/0/0/0/0",
               name, in_ready, class_valid, class_id, class_score, class_tie, sat_flag, busy);
    end
  endtask

  task automatic apply_reset_pulse();
    reset = 1'b0;
    sb.delete();
    m_first = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset_state");
    release_reset();
  endtask

  task automatic test_basic();
    exp_t e;
    send(12'd5, 12'd9, 1'b0);
    send(12'd7, 12'd2, 1'b0);
    send(12'd1, 12'd1, 1'b1);
    check_latency("basic");
    check_decision("basic", e);
    handshake("basic");
  endtask

  task automatic test_tie();
    exp_t e;
    send(12'd10, 12'd4, 1'b0);
    send(12'd0, 12'd6, 1'b1);
    check_latency("tie");
    check_decision("tie", e);
    handshake("tie");
  endtask

  task automatic test_single();
    exp_t e;
    send(12'd0, 12'd4095, 1'b1);
    check_latency("single");
    check_decision("single", e);
    handshake("single");
  endtask

  task automatic test_saturate_and_stall();
    exp_t e;
    for (int i = 1; i <= 300; i++) send(12'd4095, 12'd0, (i == 300));
    check_decision("saturate", e);
    // Stall the consumer while upstream keeps offering a sample
    in_valid  = 1'b1;
    in_sample = {12'd8, 12'd3};
    in_last   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      checks++;
      if (class_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          class_id !== e.id || class_score !== e.score || class_tie !== e.tie) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: valid=%0b rdy=%0b id=%0d score=%0d tie=%0b, required 1/0/%0d/%0d/%0b",
                 k, class_valid, in_ready, class_id, class_score, class_tie, e.id, e.score, e.tie);
      end
    end
    class_ready = 1'b1;
    @(posedge clock); #1;
    class_ready = 1'b0;
    checks++;
    if (class_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid=%0b in_ready=%0b, required 0/1", class_valid, in_ready);
    end
    @(posedge clock);
    model_accept(12'd3, 12'd8, 1'b1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL fresh_sat_clear: sat_flag=%0b, required 0", sat_flag);
    end
    check_decision("fresh_after_stall", e);
    handshake("fresh_after_stall");
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    send(12'd1, 12'd2, 1'b0);
    apply_reset_pulse();
    check_idle_outputs("reset_in_accum");
    release_reset();
    send(12'd7, 12'd3, 1'b1);
    check_decision("pre_hold_reset", e);
    apply_reset_pulse();
    check_idle_outputs("reset_in_hold");
    release_reset();
    send(12'd2, 12'd1, 1'b0);
    send(12'd0, 12'd1, 1'b1);
    check_latency("post_reset");
    check_decision("post_reset", e);
    handshake("post_reset");
  endtask

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_sample   = '0;
    in_last     = 1'b0;
    class_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_single();
    test_saturate_and_stall();
    test_reset_midrun();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d decisions outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
